// File: rtl/addsub_pipe.sv
// Pipelined N-bit adder/subtractor. The carry chain is cut into STAGES slices of W bits,
// and one slice is resolved per register stage. Valid/ready flow control lets bubbles collapse.
module addsub_pipe #(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int W = N / STAGES;

  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] vld;
  logic [N-1:0]      bp;
  logic              c0;

  assign bp = sub ? ~b : b;
  assign c0 = sub | cin;

  // A stage is ready when it is empty or everything below it can move.
  always_comb begin
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) rdy[k] = ~vld[k] | rdy[k+1];
  end

  assign in_ready = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic                 v_q, v_d, c_q, c_d, ci;
    logic [W-1:0]         sa, sb, s;
    logic [(k+1)*W-1:0]   r_q, r_d;

    assign {c_d, s} = {1'b0, sa} + {1'b0, sb} + {{W{1'b0}}, ci};

    if (k == 0) begin : g_in
      assign v_d = in_valid;
      assign sa  = a[W-1:0];
      assign sb  = bp[W-1:0];
      assign ci  = c0;
      assign r_d = s;
    end else begin : g_up
      assign v_d = g_stg[k-1].v_q;
      assign sa  = g_stg[k-1].g_op.ra_q[W-1:0];
      assign sb  = g_stg[k-1].g_op.rb_q[W-1:0];
      assign ci  = g_stg[k-1].c_q;
      assign r_d = {s, g_stg[k-1].r_q};
    end

    // Unconsumed operand slices, shifted so the next slice to add sits at bit 0.
    if (k < STAGES - 1) begin : g_op
      localparam int RW = N - (k + 1) * W;
      logic [RW-1:0] ra_q, rb_q, ra_d, rb_d;
      if (k == 0) begin : g_src
        assign ra_d = a[N-1:W];
        assign rb_d = bp[N-1:W];
      end else begin : g_src
        assign ra_d = g_stg[k-1].g_op.ra_q[N-k*W-1:W];
        assign rb_d = g_stg[k-1].g_op.rb_q[N-k*W-1:W];
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          ra_q <= '0;
          rb_q <= '0;
        end else if (rdy[k]) begin
          ra_q <= ra_d;
          rb_q <= rb_d;
        end
      end
    end

    // Carry into the MSB is recovered from the top sum bit and its operand bits.
    if (k == STAGES - 1) begin : g_last
      logic ovf_q;
      always_ff @(posedge clk) begin
        if (rst)          ovf_q <= 1'b0;
        else if (rdy[k])  ovf_q <= c_d ^ (s[W-1] ^ sa[W-1] ^ sb[W-1]);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (rdy[k]) begin
        v_q <= v_d;
        c_q <= c_d;
        r_q <= r_d;
      end
    end

    assign vld[k] = v_q;
  end

  assign out_valid = vld[STAGES-1];
  assign sum       = g_stg[STAGES-1].r_q;
  assign cout      = g_stg[STAGES-1].c_q;
  assign ovf       = g_stg[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: four configurations share one stimulus stream, each with its own
// scoreboard queue; directed timing checks target the (16,4) instance.
module tb_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, cin, sub;
  logic [31:0] a, b;
  logic [3:0]  ird, ovl, cot, ovf;
  logic [15:0] s0, s1, s2;
  logic [31:0] s3;
  logic [33:0] q [4][$];
  logic [33:0] held;
  int          nchk = 0, nerr = 0, acc0 = 0, acc_start;

  always #5 clk = ~clk;

  addsub_pipe #(.N(16), .STAGES(4)) u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ird[0]),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub), .out_valid(ovl[0]), .out_ready(out_ready),
    .sum(s0), .cout(cot[0]), .ovf(ovf[0]));
  addsub_pipe #(.N(16), .STAGES(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ird[1]),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub), .out_valid(ovl[1]), .out_ready(out_ready),
    .sum(s1), .cout(cot[1]), .ovf(ovf[1]));
  addsub_pipe #(.N(16), .STAGES(16)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ird[2]),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub), .out_valid(ovl[2]), .out_ready(out_ready),
    .sum(s2), .cout(cot[2]), .ovf(ovf[2]));
  addsub_pipe #(.N(32), .STAGES(4)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ird[3]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ovl[3]), .out_ready(out_ready),
    .sum(s3), .cout(cot[3]), .ovf(ovf[3]));

  // Reference: one full-width add, packed as {ovf, cout, sum[31:0]}.
  function automatic logic [33:0] model(int w, logic [31:0] x, logic [31:0] y, logic ci, logic sb);
    logic [31:0] mask, xx, yy;
    logic [32:0] t;
    logic        c, cm;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    xx   = x & mask;
    yy   = (sb ? ~y : y) & mask;
    t    = {1'b0, xx} + {1'b0, yy} + {32'd0, sb | ci};
    c    = t[w];
    cm   = t[w-1] ^ xx[w-1] ^ yy[w-1];
    return {c ^ cm, c, t[31:0] & mask};
  endfunction

  function automatic logic [33:0] obs(int i);
    case (i)
      0:       return {ovf[0], cot[0], 16'h0, s0};
      1:       return {ovf[1], cot[1], 16'h0, s1};
      2:       return {ovf[2], cot[2], 16'h0, s2};
      default: return {ovf[3], cot[3], s3};
    endcase
  endfunction

  task automatic chk(string tag, logic [33:0] o, logic [33:0] e);
    nchk++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Evaluated mid-cycle: the transfers seen here happen on the next rising edge.
  task automatic mon();
    if (rst) begin
      for (int i = 0; i < 4; i++) q[i].delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ovl[i] && out_ready) begin
          if (q[i].size() == 0) chk($sformatf("dut%0d extra", i), 34'(q[i].size()), 34'd1);
          else chk($sformatf("dut%0d result", i), obs(i), q[i].pop_front());
        end
        if (in_valid && ird[i]) begin
          q[i].push_back(model(i == 3 ? 32 : 16, a, b, cin, sub));
          if (i == 0) acc0++;
        end
      end
    end
  endtask

  task automatic apply(); #1; mon(); endtask
  task automatic adv(); @(posedge clk); #1; endtask

  task automatic rnd();
    a = $urandom; b = $urandom;
    cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
  endtask

  task automatic single(string tag, logic [15:0] x, logic [15:0] y, logic ci, logic sb, logic [17:0] e);
    a = {16'h0, x}; b = {16'h0, y}; cin = ci; sub = sb;
    in_valid = 1'b1; out_ready = 1'b1;
    apply(); adv();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      apply();
      chk({tag, " valid"}, 34'(ovl[0]), 34'(k == 4));
      if (k == 4) chk(tag, {16'h0, ovf[0], cot[0], s0}, {16'h0, e});
      adv();
    end
  endtask

  initial begin
    // Reset, with inputs offered that must not be accepted
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; rnd();
    adv(); apply(); adv(); apply(); adv();
    rst = 1'b0; in_valid = 1'b0;
    apply();
    chk("reset outputs", {ovf[0], cot[0], 16'h0, s0}, 34'd0);
    chk("reset out_valid", 34'(ovl), 34'd0);
    chk("reset in_ready", 34'(ird), 34'hF);
    adv();

    // Carry across every slice, signed overflow, borrow
    single("t1 ffff+1",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000);
    single("t2 7fff+1",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
    single("t2 5-7 cin",   16'h0005, 16'h0007, 1'b1, 1'b1, 18'h0FFFE);
    single("t2 8000-1",    16'h8000, 16'h0001, 1'b0, 1'b1, 18'h37FFF);
    single("add with cin", 16'h1234, 16'h0FFF, 1'b1, 1'b0, 18'h02234);

    // 16 back-to-back operations
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 16); out_ready = 1'b1; rnd();
      apply();
      chk("t3 in_ready", 34'(ird[0]), 34'd1);
      chk("t3 out_valid", 34'(ovl[0]), 34'(i >= 4));
      adv();
    end

    // Backpressure: exactly STAGES absorbed, held output stable
    acc_start = acc0; out_ready = 1'b0; in_valid = 1'b1; held = '0;
    for (int k = 0; k < 10; k++) begin
      rnd();
      apply();
      chk("t4 in_ready", 34'(ird[0]), 34'(k < 4));
      chk("t4 out_valid", 34'(ovl[0]), 34'(k >= 4));
      if (k == 4) held = obs(0);
      if (k > 4) chk("t4 held stable", obs(0), held);
      adv();
    end
    chk("t4 accepted", 34'(acc0 - acc_start), 34'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rnd();
      apply();
      chk("t4 resume in_ready", 34'(ird[0]), 34'd1);
      adv();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin apply(); adv(); end

    // Reset with three operations in flight
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; rnd(); apply(); adv();
    end
    rst = 1'b1; rnd(); apply(); adv();
    rst = 1'b0; in_valid = 1'b0;
    apply();
    chk("t5 outputs", {ovf[0], cot[0], 16'h0, s0}, 34'd0);
    chk("t5 in_ready", 34'(ird[0]), 34'd1);
    adv();
    for (int k = 0; k < 20; k++) begin
      apply();
      chk("t5 no stale", 34'(ovl), 34'd0);
      adv();
    end

    // Random valid/ready regression across all configurations
    for (int k = 0; k < 400; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rnd();
      apply(); adv();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin apply(); adv(); end
    for (int i = 0; i < 4; i++) chk($sformatf("dut%0d drained", i), 34'(q[i].size()), 34'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined N-bit adder/subtractor with valid/ready flow control. It is the successor to the team's combinational ripple-carry adder. The carry chain is cut into STAGES equal slices, and one slice is resolved per register stage. The block sits between operand producers and result consumers that run at clock rates a full N-bit ripple chain cannot meet. It sustains one operation per cycle and supports backpressure.

## Interface
- N, 16, operand and result width; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..N); slice width W = N/STAGES.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands on a/b/cin/sub are valid.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  N  operand A (unsigned or two's complement).
- b  input  N  operand B.
- cin  input  1  carry-in; used in add mode only.
- sub  input  1  0: A+B+cin; 1: A−B (A + ~B + 1), cin ignored.
- out_valid  output  1  result on sum/cout/ovf is valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  N  result.
- cout  output  1  carry-out of the MSB; in sub mode 1 means no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage k (0..STAGES−1) holds the following, carried down the pipe:
  - valid bit v[k];
  - result slices 0..k;
  - the unconsumed operand slices k+1..STAGES−1, with B already inverted when sub=1;
  - the running carry;
  - the carry into the current top bit, used for ovf.
- Stage 0 adds slice 0 of A and B' with c0 = sub ? 1 : cin. Stage k adds slice k using the carry registered by stage k−1.
- The last stage's registers drive sum/cout/ovf and out_valid = v[STAGES−1].
- Flow control, per stage:
  - ready[STAGES] = out_ready; ready[k] = !v[k] || ready[k+1]; in_ready = ready[0].
  - Stage k loads from stage k−1 (or from the inputs when k = 0) when ready[k]. The new v[k] is the upstream valid qualified by the upstream transfer.
  - When !ready[k], stage k holds all of its contents unchanged.
- Bubbles collapse: an empty stage always accepts, even while the output is stalled.
- Operations leave in strict input order. None are dropped or duplicated.
- Arithmetic is modulo 2^N. Results must be bit-identical to a single-cycle N-bit add for all inputs and for every legal (N, STAGES).
- STAGES=1 degenerates to one register stage after a full-width add.

## Timing
- Reset: all v[k]=0, out_valid=0, sum=0, cout=0, ovf=0, all internal data registers 0. in_ready=1 in the first cycle after reset.
- Latency: an operation accepted at edge t is presented at edge t+STAGES when downstream does not stall.
- Throughput is 1 op/cycle while out_ready stays high.
- With out_ready held low, the block absorbs exactly STAGES operations, after which in_ready=0.
- in_ready depends combinationally on out_ready and the v[] bits. No combinational path exists from a, b, cin, sub or in_valid to any output.
- When out_ready is low and out_valid is high, sum/cout/ovf stay stable until the transfer.
- Simultaneous input and output transfer on a full pipe is legal: the pipe advances and in_ready remains 1.
- Reset asserted mid-operation: all in-flight operations are discarded on that edge and the outputs return to their reset values. Inputs presented during reset are not accepted.

## Test plan
- Test 1 (N=16, STAGES=4): a=0xFFFF, b=0x0001, cin=0, sub=0 at cycle 0, out_ready=1 -> out_valid at cycle 4 with sum=0x0000, cout=1, ovf=0. The carry must ripple across all slice boundaries.
- Test 2, signed checks:
  - a=0x7FFF + b=0x0001 -> sum=0x8000, cout=0, ovf=1.
  - sub: a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0, ovf=0; cin must be ignored.
  - sub: a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Test 3: 16 back-to-back random operations with in_valid=1 and out_ready=1 -> in_ready stays 1 and 16 results appear on consecutive cycles 4..19, in order, matching the reference model.
- Test 4, backpressure: out_ready=0 for 10 cycles under continuous in_valid -> exactly 4 operations accepted, then in_ready=0 and the held output is stable. Release out_ready -> the 4 results drain in order and acceptance resumes the same cycle.
- Test 5: assert rst while 3 operations are in flight -> next cycle out_valid=0, sum=0, cout=0, ovf=0, in_ready=1. No stale result appears after reset.
- Test 6: regress Tests 1–4 with (N, STAGES) = (16,1), (16,16) and (32,4) under random out_ready and in_valid -> scoreboard shows zero mismatches, no drops and no duplicates.
